// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with prescaler, one-shot or
// periodic reload, and a one-cycle terminal-count pulse.
// Optional sticky interrupt flag enabled by defining DOWN_TIMER_IRQ_EN;
// without it o_irq is tied low and i_irq_clear is ignored.
module down_timer #(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_ce,
  input  logic                      i_load,
  input  logic [WIDTH-1:0]          i_load_value,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  logic                      i_periodic,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic                      i_irq_clear,
  output logic [WIDTH-1:0]          o_count,
  output logic                      o_running,
  output logic                      o_done,
  output logic                      o_tc,
  output logic                      o_irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          count_q, count_d;
  logic [WIDTH-1:0]          reload_q, reload_d;
  logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic                      tc_q, tc_d;
  logic                      running_q, running_d;
  logic                      done_q, done_d;

  logic                      tick;
  logic                      expire;
  logic [WIDTH-1:0]          next_reload;
  logic [WIDTH-1:0]          start_value;

  // Next-state logic: load/start/stop handling, prescaler and countdown.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    reload_d    = reload_q;
    pcnt_d      = pcnt_q;
    tick        = 1'b0;
    expire      = 1'b0;
    // A load coinciding with expiry or start takes effect immediately.
    next_reload = i_load ? i_load_value : reload_q;
    start_value = i_load ? i_load_value : count_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_load) begin
          reload_d = i_load_value;
          count_d  = i_load_value;
          state_d  = ST_IDLE;
        end
        // Stop outranks start; a zero interval never starts.
        if (i_start && !i_stop && (start_value != '0)) begin
          state_d = ST_RUN;
          pcnt_d  = '0;
        end
      end
      ST_RUN: begin
        if (i_load) begin
          reload_d = i_load_value;
        end
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_ce) begin
          // Equality compare lets pcnt wrap if the prescale drops below it.
          if (pcnt_q == i_prescale) begin
            tick   = 1'b1;
            pcnt_d = '0;
          end else begin
            pcnt_d = pcnt_q + PRESCALE_WIDTH'(1);
          end
          if (tick) begin
            // Expiry is caught at 1 so the count never underflows.
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              expire = 1'b1;
              if (i_periodic && (next_reload != '0)) begin
                count_d = next_reload;
              end else begin
                count_d = '0;
                state_d = ST_DONE;
              end
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tc_d      = expire;
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      pcnt_q    <= '0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      pcnt_q    <= pcnt_d;
      tc_q      <= tc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

`ifdef DOWN_TIMER_IRQ_EN
  logic irq_q;

  // Sticky interrupt: set alongside o_tc, set beats a simultaneous clear.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      irq_q <= 1'b0;
    end else if (expire) begin
      irq_q <= 1'b1;
    end else if (i_irq_clear) begin
      irq_q <= 1'b0;
    end
  end

  assign o_irq = irq_q;
`else
  logic unused_irq_clear;

  assign unused_irq_clear = i_irq_clear;
  assign o_irq            = 1'b0;
`endif

  assign o_count   = count_q;
  assign o_running = running_q;
  assign o_done    = done_q;
  assign o_tc      = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: scoreboard bench for down_timer. Expected per-cycle outputs
// are pushed as each cycle's stimulus is driven and popped one cycle later.
module tb_down_timer;

  localparam int W  = 32;
  localparam int PW = 8;
`ifdef DOWN_TIMER_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          load;
  logic [W-1:0]  load_value;
  logic [PW-1:0] prescale;
  logic          periodic;
  logic          start;
  logic          stop;
  logic          irq_clear;
  logic [W-1:0]  count;
  logic          running;
  logic          done;
  logic          tc;
  logic          irq;

  down_timer #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_ce         (ce),
    .i_load       (load),
    .i_load_value (load_value),
    .i_prescale   (prescale),
    .i_periodic   (periodic),
    .i_start      (start),
    .i_stop       (stop),
    .i_irq_clear  (irq_clear),
    .o_count      (count),
    .o_running    (running),
    .o_done       (done),
    .o_tc         (tc),
    .o_irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] cnt;
    logic         run;
    logic         dn;
    logic         tcx;
    logic         irqx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [W-1:0] c, input logic r,
                         input logic d, input logic t, input logic i);
    exp_t e;
    e.tag = tag; e.cnt = c; e.run = r; e.dn = d; e.tcx = t; e.irqx = i;
    exp_q.push_back(e);
  endtask

  // Advance one clock and compare the DUT outputs against the oldest entry.
  task automatic clk_step();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({e.tag, ".count"},   count,         e.cnt);
      check({e.tag, ".running"}, W'(running),   W'(e.run));
      check({e.tag, ".done"},    W'(done),      W'(e.dn));
      check({e.tag, ".tc"},      W'(tc),        W'(e.tcx));
      check({e.tag, ".irq"},     W'(irq),       W'(e.irqx));
      $display("txn %s count=%0d run=%0b done=%0b tc=%0b irq=%0b",
               e.tag, count, running, done, tc, irq);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; load = 1'b0; load_value = '0; prescale = '0;
    periodic = 1'b0; start = 1'b0; stop = 1'b0; irq_clear = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst.count", count, '0);
    check("rst.running", W'(running), '0);
    check("rst.done", W'(done), '0);
    check("rst.tc", W'(tc), '0);
    check("rst.irq", W'(irq), '0);
    rst = 1'b0;

    // Start with count 0 is ignored.
    start = 1'b1;
    sb_push("start_zero", 0, 0, 0, 0, 0); clk_step();
    start = 1'b0;

    // One-shot, load 5 with start in the same cycle, P=0.
    load = 1'b1; load_value = 5; start = 1'b1;
    sb_push("os_start", 5, 1, 0, 0, 0); clk_step();
    load = 1'b0; start = 1'b0;
    for (int v = 4; v >= 1; v--) begin
      sb_push("os_dec", W'(v), 1, 0, 0, 0); clk_step();
    end
    sb_push("os_expire", 0, 0, 1, 1, IRQ_EN); clk_step();
    start = 1'b1;
    sb_push("done_start0", 0, 0, 1, 0, IRQ_EN); clk_step();
    start = 1'b0; irq_clear = 1'b1;
    sb_push("irq_clr", 0, 0, 1, 0, 0); clk_step();

    // Periodic, load 3, P=2 -> tc every 9 cycles; clear held (set wins).
    periodic = 1'b1; prescale = 2; load = 1'b1; load_value = 3;
    sb_push("per_load", 3, 0, 0, 0, 0); clk_step();
    load = 1'b0; start = 1'b1;
    sb_push("per_start", 3, 1, 0, 0, 0); clk_step();
    start = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      int j;
      logic [W-1:0] c;
      j = ((k - 1) % 9) + 1;
      c = (j < 3) ? 3 : (j < 6) ? 2 : (j < 9) ? 1 : 3;
      sb_push("per_run", c, 1, 0, (j == 9), IRQ_EN && (j == 9)); clk_step();
    end
    stop = 1'b1;
    sb_push("per_stop", 3, 0, 0, 0, 0); clk_step();
    stop = 1'b0; irq_clear = 1'b0;

    // Periodic P=0, load 4; reload changed mid-run and at expiry.
    prescale = 0; load = 1'b1; load_value = 4; start = 1'b1;
    sb_push("rl_start", 4, 1, 0, 0, 0); clk_step();
    start = 1'b0; load_value = 9;
    sb_push("rl_midload", 3, 1, 0, 0, 0); clk_step();
    load = 1'b0;
    sb_push("rl_dec", 2, 1, 0, 0, 0); clk_step();
    sb_push("rl_dec", 1, 1, 0, 0, 0); clk_step();
    load = 1'b1; load_value = 2;
    sb_push("rl_expload", 2, 1, 0, 1, IRQ_EN); clk_step();
    load = 1'b0;
    sb_push("rl_dec", 1, 1, 0, 0, IRQ_EN); clk_step();
    sb_push("rl_expire", 2, 1, 0, 1, IRQ_EN); clk_step();
    sb_push("rl_dec", 1, 1, 0, 0, IRQ_EN); clk_step();
    // Stop coincident with a tick at count 1: no expiry.
    stop = 1'b1;
    sb_push("stop_tick", 1, 0, 0, 0, IRQ_EN); clk_step();
    // Start and stop together from IDLE: stays IDLE.
    start = 1'b1;
    sb_push("start_stop", 1, 0, 0, 0, IRQ_EN); clk_step();
    start = 1'b0; stop = 1'b0;

    // Clock-enable gating: one-shot, load 3, ce pattern 0,1,0,1,0,1,0.
    periodic = 1'b0; ce = 1'b0; load = 1'b1; load_value = 3; start = 1'b1;
    sb_push("ce_start", 3, 1, 0, 0, IRQ_EN); clk_step();
    load = 1'b0; start = 1'b0;
    ce = 1'b1; sb_push("ce_on", 2, 1, 0, 0, IRQ_EN); clk_step();
    ce = 1'b0; sb_push("ce_off", 2, 1, 0, 0, IRQ_EN); clk_step();
    ce = 1'b1; sb_push("ce_on", 1, 1, 0, 0, IRQ_EN); clk_step();
    ce = 1'b0; sb_push("ce_off", 1, 1, 0, 0, IRQ_EN); clk_step();
    ce = 1'b1; sb_push("ce_expire", 0, 0, 1, 1, IRQ_EN); clk_step();
    ce = 1'b0; sb_push("ce_done", 0, 0, 1, 0, IRQ_EN); clk_step();
    irq_clear = 1'b1;
    sb_push("ce_irqclr", 0, 0, 1, 0, 0); clk_step();
    irq_clear = 1'b0;
    sb_push("ce_irqlow", 0, 0, 1, 0, 0); clk_step();

    // Asynchronous reset mid-RUN with count 7.
    load = 1'b1; load_value = 7; start = 1'b1; ce = 1'b0;
    sb_push("ar_start", 7, 1, 0, 0, 0); clk_step();
    load = 1'b0; start = 1'b0;
    sb_push("ar_hold", 7, 1, 0, 0, 0); clk_step();
    #3 rst = 1'b1;
    #1;
    check("arst.count", count, '0);
    check("arst.running", W'(running), '0);
    check("arst.done", W'(done), '0);
    check("arst.tc", W'(tc), '0);
    check("arst.irq", W'(irq), '0);
    @(posedge clk);
    #1;
    rst = 1'b0; ce = 1'b1;
    sb_push("post_rst", 0, 0, 0, 0, 0); clk_step();

    check("sb_left", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
